rs_enc_32_28: RTL and testbench
===============================

# rs_enc_32_28

Byte-serial systematic RS(32,28) encoder over GF(256), the transmit-side counterpart of the rs_dec_* decoder chain. It accepts 28 data bytes per frame, passes them through unchanged, then appends 4 parity bytes computed by a degree-4 LFSR. The output is a 32-byte codeword whose syndromes S0..S3 are all zero. The block feeds the C1/C2 interleaver path and serves as the golden codeword source for decoder benches.

## Interface
- Parameters: none. Field polynomial, N, K and generator coefficients come from rs_pkg.
- i_clk  in  1  clock; all state updates on its rising edge
- i_resb  in  1  asynchronous active-low reset
- i_data  in  8  data byte; first byte is the x^31 coefficient
- i_valid  in  1  i_data is valid
- o_ready  out  1  block accepts i_data this cycle
- o_data  out  8  codeword byte, data bytes then parity p3,p2,p1,p0
- o_valid  out  1  o_data is valid
- i_ready  in  1  downstream accepts o_data
- o_sof  out  1  o_data is codeword byte 0
- o_eof  out  1  o_data is codeword byte 31 (p0)

## Operation
- Field: GF(2^8), primitive polynomial 0x11D, alpha = 0x02.
- Generator: g(x) = (x+1)(x+a)(x+a^2)(x+a^3) = x^4 + 0x0F x^3 + 0x36 x^2 + 0x78 x + 0x40. Names: G3=0x0F, G2=0x36, G1=0x78, G0=0x40.
- Parity registers p3..p0, 8 bits each.
- Input handshake: accept = i_valid & o_ready.
- On each accept in the DATA state:
  - fb = i_data ^ p3
  - p3 <= p2 ^ G3·fb; p2 <= p1 ^ G2·fb; p1 <= p0 ^ G1·fb; p0 <= G0·fb
  - All operations are GF multiply/XOR; no carries.
- Output handshake: transfer = o_valid & i_ready. The output register holds one byte.
- o_ready = (state==DATA) & (~o_valid | i_ready).
- FSM states:
  - IDLE: after reset; parity registers are zero. Goes to DATA on the next cycle.
  - DATA: each accept loads the output register with i_data and increments cnt (5-bit). On the accept with cnt==27: go to PARITY and clear cnt.
  - PARITY: o_ready=0. On each cycle where the output register is empty or transferring, load p3 into it. Shift p3<=p2, p2<=p1, p1<=p0, p0<=0 and increment cnt. After the 4th load: cnt clears, state goes to DATA. The parity registers are then all zero, ready for the next frame.
- o_sof is set with the output byte loaded for data index 0. o_eof is set with the load of p0. Both are registered together with o_data.
- The output register holds o_data, o_valid, o_sof and o_eof stable while o_valid & ~i_ready (no drop, no duplicate).
- i_data is ignored when ~o_ready.

## Timing
- Reset values: o_data=0x00, o_valid=0, o_sof=0, o_eof=0, o_ready=0. State=IDLE; cnt and p3..p0 are 0.
- o_ready first rises 1 cycle after reset release.
- Latency: a byte accepted in cycle t appears on o_data in cycle t+1.
- With i_valid and i_ready held high:
  - 28 data cycles, then 4 parity cycles, i.e. 32 cycles per frame, 100% output occupancy.
  - The next frame's first byte is accepted in the cycle p0 is presented.
- Backpressure: o_ready drops combinationally while o_valid & ~i_ready. LFSR state and cnt are frozen.
- The parity path runs after the last data accept with no bubble: p3 appears the cycle after data byte 27.
- Reset asserted mid-frame: all state is cleared immediately. The partial codeword is lost, and the next accepted byte is byte 0 of a new frame.

## Structure
- rs_pkg holds the shared constants:
  - GF_POLY=9'h11D, RS_N=32, RS_K=28, RS_NPAR=4
  - RS_G0..RS_G3
  - function gf256_mul, shared with the rs_dec_* blocks
- Sub-module gf256_mul_const (parameter C, 8-bit in/out): constant multiplier built as an XOR matrix, instanced 4×.

## Test plan
- Reset, then 28×0x00 with full throughput -> 28×0x00 then parity 00,00,00,00; o_sof on byte 0, o_eof on byte 31; 32 consecutive valid cycles.
- 27×0x00 then 0x01 -> parity 0F,36,78,40.
- 27×0x00 then 0x02 -> parity 1E,6C,F0,80.
- 1000 random frames -> a reference model shows syndromes S0..S3 = 0 for every codeword, and data bytes are passed through unchanged.
- Random i_valid/i_ready toggling, including i_ready low during the parity phase -> byte stream identical to the no-stall run; o_data stable while stalled; no input accepted during PARITY.
- i_resb pulsed after 10 bytes, then a fresh 27×0x00+0x01 frame -> parity 0F,36,78,40 and o_sof on that frame's first byte.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared RS(32,28) constants and GF(256) arithmetic for the encoder and
// the rs_dec_* decoder chain.
package rs_pkg;

  localparam logic [8:0] GF_POLY  = 9'h11D;
  localparam int         RS_N     = 32;
  localparam int         RS_K     = 28;
  localparam int         RS_NPAR  = 4;
  localparam int         CNT_W    = $clog2(RS_N);

  // g(x) = (x+1)(x+a)(x+a^2)(x+a^3) = x^4 + G3 x^3 + G2 x^2 + G1 x + G0
  localparam logic [7:0] RS_G0    = 8'h40;
  localparam logic [7:0] RS_G1    = 8'h78;
  localparam logic [7:0] RS_G2    = 8'h36;
  localparam logic [7:0] RS_G3    = 8'h0F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY
  } enc_state_e;

  // Shift-and-add GF(256) multiply, reduced by GF_POLY.
  function automatic logic [7:0] gf256_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc ^= sh;
      sh = sh[7] ? ((sh << 1) ^ GF_POLY[7:0]) : (sh << 1);
    end
    return acc;
  endfunction

endpackage

// File: rtl/rs_enc_32_28_if.sv
// Byte-stream interface of the RS(32,28) encoder: input stream
// (i_data/i_valid/o_ready) and output stream (o_data/o_valid/i_ready,
// framing flags). Signal names are from the encoder's point of view.
interface rs_enc_32_28_if;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_sof;
  logic       o_eof;

  // Encoder side
  modport slave (
    input  i_data, i_valid, i_ready,
    output o_ready, o_data, o_valid, o_sof, o_eof
  );

  // Source/sink side
  modport master (
    output i_data, i_valid, i_ready,
    input  o_ready, o_data, o_valid, o_sof, o_eof
  );
endinterface

// File: rtl/gf256_mul_const.sv
// Multiply by a constant in GF(256): an 8x8 XOR matrix whose column j is
// C * alpha^j, folded to constants at elaboration.
import rs_pkg::*;

module gf256_mul_const #(
  parameter logic [7:0] C = 8'h01
) (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // XOR together the matrix columns selected by the set input bits.
  always_comb begin
    // NOTE: dout gets a default before the loop so no path leaves it unassigned (no latch).
    dout = '0;
    for (int j = 0; j < 8; j++) begin
      dout ^= {8{din[j]}} & gf256_mul(C, 8'(1 << j));
    end
  end

endmodule

// File: rtl/rs_enc_32_28.sv
// Byte-serial systematic RS(32,28) encoder. Data bytes pass through one
// output register while a degree-4 LFSR accumulates the remainder; the
// four parity bytes p3..p0 are then shifted out with no bubble.
import rs_pkg::*;

module rs_enc_32_28 (
  input  logic           i_clk,
  input  logic           i_resb,
  rs_enc_32_28_if.slave  bus
);

  enc_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       p3, p2, p1, p0;

  logic [7:0]       data_q;
  logic             valid_q;
  logic             sof_q;
  logic             eof_q;

  logic [7:0]       fb;
  logic [7:0]       m3, m2, m1, m0;
  logic             out_free;
  logic             accept;

  // The output register can take a new byte when empty or draining.
  assign out_free     = ~valid_q | bus.i_ready;
  assign bus.o_ready  = (state == ST_DATA) & out_free;
  assign accept       = bus.i_valid & bus.o_ready;

  assign bus.o_data   = data_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_sof    = sof_q;
  assign bus.o_eof    = eof_q;

  assign fb = bus.i_data ^ p3;

  gf256_mul_const #(.C(RS_G3)) u_mul_g3 (.din(fb), .dout(m3));
  gf256_mul_const #(.C(RS_G2)) u_mul_g2 (.din(fb), .dout(m2));
  gf256_mul_const #(.C(RS_G1)) u_mul_g1 (.din(fb), .dout(m1));
  gf256_mul_const #(.C(RS_G0)) u_mul_g0 (.din(fb), .dout(m0));

  // Frame FSM, LFSR and output register, all updated together.
  always_ff @(posedge i_clk or negedge i_resb) begin
    if (!i_resb) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state   <= ST_IDLE;
      cnt     <= '0;
      p3      <= '0;
      p2      <= '0;
      p1      <= '0;
      p0      <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      // A transferred byte empties the register unless a new load below refills it.
      if (valid_q && bus.i_ready) valid_q <= 1'b0;

      case (state)
        ST_IDLE: begin
          state <= ST_DATA;
        end

        ST_DATA: begin
          if (accept) begin
            data_q  <= bus.i_data;
            valid_q <= 1'b1;
            sof_q   <= (cnt == '0);
            eof_q   <= 1'b0;
            p3      <= p2 ^ m3;
            p2      <= p1 ^ m2;
            p1      <= p0 ^ m1;
            p0      <= m0;
            if (cnt == CNT_W'(RS_K - 1)) begin
              cnt   <= '0;
              state <= ST_PARITY;
            end else begin
              cnt   <= cnt + 1'b1;
            end
          end
        end

        ST_PARITY: begin
          if (out_free) begin
            data_q  <= p3;
            valid_q <= 1'b1;
            sof_q   <= 1'b0;
            eof_q   <= (cnt == CNT_W'(RS_NPAR - 1));
            p3      <= p2;
            p2      <= p1;
            p1      <= p0;
            p0      <= '0;
            if (cnt == CNT_W'(RS_NPAR - 1)) begin
              cnt   <= '0;
              state <= ST_DATA;
            end else begin
              cnt   <= cnt + 1'b1;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs_enc_32_28.sv
// Scoreboard bench for rs_enc_32_28: the driver pushes expected bytes as it
// issues them; an independent monitor pops and compares on every output
// transfer and checks codeword syndromes with a log/antilog GF model.
module tb_rs_enc_32_28;

  logic i_clk  = 1'b0;
  logic i_resb = 1'b0;

  rs_enc_32_28_if bus ();

  rs_enc_32_28 dut (
    .i_clk  (i_clk),
    .i_resb (i_resb),
    .bus    (bus)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] data;
    bit         chk_data;
    bit         sof;
    bit         eof;
    bit         full_rate;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  bit         stall_mode = 1'b0;
  int         cyc = 0;
  logic [7:0] gexp [256];
  int         glog [256];
  logic [7:0] frame [28];

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic finish_bench();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return gexp[(glog[a] + glog[b]) % 255];
  endfunction

  // Downstream ready: always high, or random while stall_mode is set.
  // Changed just after the rising edge so it is stable for negedge sampling.
  initial begin
    bus.i_ready = 1'b1;
    forever begin
      @(posedge i_clk);
      #2;
      bus.i_ready = stall_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor: compares every transferred byte against the scoreboard.
  initial begin : monitor
    int         pos;
    int         sof_cyc;
    bit         prev_stall;
    logic [7:0] held_d;
    logic       held_s;
    logic       held_e;
    logic [7:0] cw [32];
    logic [7:0] s;
    exp_t       e;
    pos = 0;
    sof_cyc = 0;
    prev_stall = 1'b0;
    held_d = '0;
    held_s = 1'b0;
    held_e = 1'b0;
    forever begin
      @(negedge i_clk);
      if (!i_resb) begin
        sb.delete();
        pos = 0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid_held", bus.o_valid, 1'b1);
          check("stall_data_held",  bus.o_data,  held_d);
          check("stall_sof_held",   bus.o_sof,   held_s);
          check("stall_eof_held",   bus.o_eof,   held_e);
        end
        prev_stall = 1'b0;
        if (bus.o_valid && pos >= 27 && pos <= 30)
          check("ready_low_in_parity", bus.o_ready, 1'b0);
        if (bus.o_valid && !bus.i_ready) begin
          prev_stall = 1'b1;
          held_d = bus.o_data;
          held_s = bus.o_sof;
          held_e = bus.o_eof;
        end
        if (bus.o_valid && bus.i_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got byte %0h, required no output", bus.o_data);
          end else begin
            e = sb.pop_front();
            if (e.chk_data) check($sformatf("data[%0d]", pos), bus.o_data, e.data);
            check($sformatf("sof[%0d]", pos), bus.o_sof, e.sof);
            check($sformatf("eof[%0d]", pos), bus.o_eof, e.eof);
            if (pos < 32) cw[pos] = bus.o_data;
            if (e.sof) sof_cyc = cyc;
            if (e.eof) begin
              for (int i = 0; i < 4; i++) begin
                s = 8'h00;
                for (int k = 0; k < 32; k++) s = gmul(s, gexp[i]) ^ cw[k];
                check($sformatf("syndrome_S%0d", i), s, 8'h00);
              end
              if (e.full_rate) check("frame_cycles", cyc - sof_cyc, 31);
              pos = 0;
            end else begin
              pos++;
            end
          end
        end
      end
    end
  end

  // Offer one byte until accepted; push its expectation at the accept edge.
  task automatic send_byte(input logic [7:0] b, input exp_t e);
    int n;
    n = 0;
    if (stall_mode) begin
      while ($urandom_range(0, 3) == 0) begin
        bus.i_valid = 1'b0;
        bus.i_data  = 8'($urandom_range(0, 255));
        @(negedge i_clk);
      end
    end
    bus.i_data  = b;
    bus.i_valid = 1'b1;
    while (!bus.o_ready) begin
      @(negedge i_clk);
      n++;
      if (n > 200) begin
        errors++;
        checks++;
        $display("FAIL accept_timeout: o_ready stayed 0 for %0d cycles, required 1", n);
        finish_bench();
      end
    end
    sb.push_back(e);
    @(posedge i_clk);
    #1 bus.i_valid = 1'b0;
    @(negedge i_clk);
  endtask

  // Send frame[] and queue the four parity expectations {p3,p2,p1,p0}.
  task automatic send_frame(input logic [31:0] par, input bit par_known);
    exp_t e;
    for (int k = 0; k < 28; k++) begin
      e.data = frame[k];
      e.chk_data = 1'b1;
      e.sof = (k == 0);
      e.eof = 1'b0;
      e.full_rate = !stall_mode;
      send_byte(frame[k], e);
    end
    for (int j = 0; j < 4; j++) begin
      e.data = par[31 - 8*j -: 8];
      e.chk_data = par_known;
      e.sof = 1'b0;
      e.eof = (j == 3);
      e.full_rate = !stall_mode;
      sb.push_back(e);
    end
  endtask

  task automatic directed_frame(input logic [7:0] last, input logic [31:0] par);
    for (int k = 0; k < 28; k++) frame[k] = 8'h00;
    frame[27] = last;
    send_frame(par, 1'b1);
  endtask

  task automatic random_frame();
    for (int k = 0; k < 28; k++) frame[k] = 8'($urandom_range(0, 255));
    send_frame(32'h0, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge i_clk);
    i_resb = 1'b0;
    bus.i_valid = 1'b0;
    #1;
    check("rst_o_data",  bus.o_data,  8'h00);
    check("rst_o_valid", bus.o_valid, 1'b0);
    check("rst_o_sof",   bus.o_sof,   1'b0);
    check("rst_o_eof",   bus.o_eof,   1'b0);
    check("rst_o_ready", bus.o_ready, 1'b0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_resb = 1'b1;
    #1 check("ready_at_release", bus.o_ready, 1'b0);
    @(negedge i_clk);
    check("ready_one_cycle_after_release", bus.o_ready, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0) begin
      @(negedge i_clk);
      n++;
      if (n > 1000) begin
        errors++;
        checks++;
        $display("FAIL drain_timeout: %0d bytes outstanding, required 0", sb.size());
        finish_bench();
      end
    end
    @(negedge i_clk);
  endtask

  // Main stimulus sequence.
  initial begin
    logic [8:0] x;
    exp_t       e;
    x = 9'h001;
    for (int i = 0; i < 255; i++) begin
      gexp[i] = x[7:0];
      glog[x[7:0]] = i;
      x = x << 1;
      if (x[8]) x ^= 9'h11D;
    end
    gexp[255] = 8'h01;
    glog[0] = 0;

    bus.i_valid = 1'b0;
    bus.i_data  = 8'h00;
    apply_reset();

    // Full throughput, directed vectors with hand-computed parity.
    directed_frame(8'h00, 32'h00000000);
    directed_frame(8'h01, 32'h0F367840);
    directed_frame(8'h02, 32'h1E6CF080);

    // Random frames: pass-through and zero syndromes.
    for (int f = 0; f < 1000; f++) random_frame();
    drain();

    // Random input gaps and downstream stalls.
    stall_mode = 1'b1;
    directed_frame(8'h01, 32'h0F367840);
    directed_frame(8'h02, 32'h1E6CF080);
    for (int f = 0; f < 60; f++) random_frame();
    directed_frame(8'h00, 32'h00000000);
    drain();
    stall_mode = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);

    // Reset in the middle of a frame, then a clean frame.
    for (int k = 0; k < 10; k++) begin
      e.data = 8'(k + 1);
      e.chk_data = 1'b1;
      e.sof = (k == 0);
      e.eof = 1'b0;
      e.full_rate = 1'b0;
      send_byte(8'(k + 1), e);
    end
    apply_reset();
    directed_frame(8'h01, 32'h0F367840);
    drain();

    finish_bench();
  end

endmodule
